// File: rtl/mini_src_control_unit.sv
// ---------------------------------------------------------------------------
// mini_src_control_unit
//
// Hardwired control sequencer for the Mini-SRC datapath. A single registered
// state walks fetch (T0, T1, optional T1W memory wait, T2) and then the
// execute steps T3..T6 selected by the instruction class decoded from the IR.
// Every datapath strobe is a combinational decode of the current state and
// the IR. The strobes are held for the whole state cycle, so the datapath
// captures them on the rising edge that ends the state.
//
// IR field layout: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
// The IR contents are only meaningful from T3 onward. Fetch-step decode
// never looks at ir.
// ---------------------------------------------------------------------------
module mini_src_control_unit #(
  parameter int NREGS       = 16,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] R_in,
  output logic [NREGS-1:0] R_out,
  output logic [4:0]       alu_op,
  output logic             run,
  output logic             illegal,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  // Execute-sequence families. Each family shares one T3..T6 recipe.
  typedef enum logic [2:0] {
    C_ALU3,     // Ra <= Rb op Rc
    C_MULDIV,   // HI:LO <= Ra op Rb
    C_UNARY,    // Ra <= op Rb
    C_HALT,
    C_ILLEGAL
  } iclass_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     cur;
  iclass_t    icls;
  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       fetch_done;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  // The immediate and constant field is not used by any supported instruction.
  assign unused_ir = ^ir[14:0];

  // Memory read completes this cycle. With the wait option off, a read always takes one cycle.
  assign fetch_done = mem_ready | ~MEM_WAIT_EN;

  // One-hot register select. An index outside NREGS selects nothing, so the bus is never double-driven.
  function automatic logic [NREGS-1:0] reg_sel(input logic [3:0] idx);
    logic [NREGS-1:0] sel;
    for (int i = 0; i < NREGS; i++) begin
      sel[i] = (int'(idx) == i);
    end
    return sel;
  endfunction

  // Classify the opcode into its execute-sequence family.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    icls = C_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  icls = C_ALU3;
      OP_MUL, OP_DIV:                 icls = C_MULDIV;
      OP_NEG, OP_NOT:                 icls = C_UNARY;
      OP_HALT:                        icls = C_HALT;
      default:                        icls = C_ILLEGAL;
    endcase
  end

  // Sequencer state register. Clear forces IDLE immediately and drops any instruction in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      cur <= S_IDLE;
    end else begin
      case (cur)
        S_IDLE: cur <= S_T0;
        S_T0:   cur <= S_T1;
        S_T1:   cur <= fetch_done ? S_T2 : S_T1W;
        S_T1W:  cur <= fetch_done ? S_T2 : S_T1W;
        S_T2:   cur <= S_T3;
        S_T3: begin
          case (icls)
            C_ALU3, C_MULDIV, C_UNARY: cur <= S_T4;
            C_HALT:                    cur <= S_HALT;
            default:                   cur <= S_T0;
          endcase
        end
        S_T4: begin
          case (icls)
            C_ALU3, C_MULDIV: cur <= S_T5;
            default:          cur <= S_T0;
          endcase
        end
        S_T5: begin
          case (icls)
            C_MULDIV: cur <= S_T6;
            default:  cur <= S_T0;
          endcase
        end
        S_T6:   cur <= S_T0;
        S_HALT: cur <= S_HALT;
        default: cur <= S_IDLE;
      endcase
    end
  end

  // Strobe decode for the current step. The defaults keep IDLE and HALT completely quiet.
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    R_in     = '0;
    R_out    = '0;
    alu_op   = 5'b00000;
    illegal  = 1'b0;

    case (cur)
      // MAR <= PC, Z <= PC + 1
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      // PC <= Z, start the memory read into MDR
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      // Keep the read open. PC was already updated in T1.
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      // IR <= MDR
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        case (icls)
          C_ALU3: begin
            R_out = reg_sel(rb);
            Yin   = 1'b1;
          end
          C_MULDIV: begin
            R_out = reg_sel(ra);
            Yin   = 1'b1;
          end
          C_UNARY: begin
            R_out   = reg_sel(rb);
            alu_op  = opcode;
            Zlowin  = 1'b1;
            Zhighin = 1'b1;
          end
          C_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (icls)
          C_ALU3: begin
            R_out   = reg_sel(rc);
            alu_op  = opcode;
            Zlowin  = 1'b1;
            Zhighin = 1'b1;
          end
          C_MULDIV: begin
            R_out   = reg_sel(rb);
            alu_op  = opcode;
            Zlowin  = 1'b1;
            Zhighin = 1'b1;
          end
          C_UNARY: begin
            Zlowout = 1'b1;
            R_in    = reg_sel(ra);
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (icls)
          C_ALU3: begin
            Zlowout = 1'b1;
            R_in    = reg_sel(ra);
          end
          C_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        if (icls == C_MULDIV) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign run   = (cur != S_IDLE) && (cur != S_HALT);
  assign state = cur;

endmodule
